dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator between the execute stage and the byte-addressed data memory.
- Memory-side encoding:
  - mem_read[1:0]: 01 byte, 10 half, 11 word; mem_read[2]=1 means sign-extend.
  - mem_write: 01 byte, 10 half, 11 word.
  - The memory returns read data combinationally and commits writes on the clk edge.
- Accepts one request at a time on a valid/ready handshake, issues registered memory cycles, and returns a one-cycle response pulse.
- Misaligned halfword/word accesses are split into byte accesses and the result is reassembled.

Parameters:
- ADDR_WIDTH, 32, byte-address width on both sides.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU idle, can accept
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned
- req_read  in  3  load type, memory encoding
- req_write  in  2  store type, memory encoding
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  load result, extended per req_read[2]
- rsp_misaligned  out  1  misaligned-trap flag (see Optional Feature)
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  DATA_WIDTH  memory write data
- m_read  out  3  memory read control
- m_write  out  2  memory write control
- m_rdata  in  DATA_WIDTH  memory read data, combinational

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0.
  - rsp_rdata=0, rsp_misaligned=0.
  - m_addr=0, m_wdata=0, m_read=0, m_write=0.
- FSM states are IDLE, ACCESS, RESP.
- IDLE: req_ready=1. If req_valid=1, capture addr, wdata, read and write on that edge and go to ACCESS.
- Op classification:
  - Store if req_write!=0. A store takes precedence, so req_read is ignored when both are nonzero.
  - Otherwise a load if req_read[1:0]!=0.
  - Otherwise a no-op.
- A no-op goes directly to RESP with rdata=0 and makes no memory cycle.
- Alignment rules:
  - Byte accesses are always aligned.
  - Half is aligned iff addr[0]=0.
  - Word is aligned iff addr[1:0]=0.
- Aligned access: ACCESS lasts 1 cycle and drives m_addr=addr and m_read/m_write equal to the captured codes. For a load, m_rdata is captured at the end of the cycle.
- Misaligned access: ACCESS lasts N cycles (N=2 for half, N=4 for word) with byte counter k=0..N-1.
  - Each cycle drives m_addr=addr+k, computed mod 2^ADDR_WIDTH.
  - Loads use m_read=3'b001 (zero-extended byte) and place m_rdata[7:0] into assembly byte k.
  - Stores use m_write=2'b01 with m_wdata[7:0]=wdata byte k.
- m_read=0 and m_write=0 in every non-ACCESS cycle.
- RESP: rsp_valid=1 for exactly one cycle, then the FSM returns to IDLE. req_ready=0 in ACCESS and RESP.
- rsp_rdata:
  - Loads are extended from the assembled byte/half by req_read[2] (sign-extend if 1, else zero-extend).
  - A word load is passed unmodified.
  - Stores and no-ops return 0.
  - rsp_rdata holds its value until the next response.
- Latency from the accepting edge to rsp_valid: aligned 2 cycles, misaligned N+1 cycles, no-op 1 cycle.
- A back-to-back request can be accepted in the cycle after RESP at the earliest.
- rsp has no backpressure. Request inputs are ignored while req_ready=0.
- rst_n asserted mid-operation aborts immediately and all outputs go to their reset values. Store bytes already committed remain in memory; no response is produced.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned load/store makes no memory access. The FSM goes from IDLE directly to RESP, with rsp_misaligned=1 and rsp_rdata=0 during the rsp_valid pulse.
- Not defined: misaligned accesses are split as described above, and rsp_misaligned is constantly 0.

Test Plan:
- Aligned word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 -> exactly one m_write=11 cycle; load rsp_rdata=0xDEADBEEF 2 cycles after accept.
- Byte 0x80 at addr 0x21:
  - Signed byte load (req_read=101) -> rsp_rdata=0xFFFFFF80.
  - Unsigned byte load (001) -> 0x00000080.
- Misaligned word store addr=0x13, wdata=0x11223344 -> four byte writes at 0x13..0x16 carrying 44,33,22,11.
  - A following word load at 0x13 takes four m_read=001 cycles and returns 0x11223344, with rsp_valid 5 cycles after accept.
- Misaligned signed half load at addr=0xFFFFFFFF with mem[0xFFFFFFFF]=0x34, mem[0x0]=0x92 -> m_addr wraps to 0x0; rsp_rdata=0xFFFF9234.
- rst_n pulsed during cycle 2 of a misaligned word store at 0x41 -> only bytes 0x41 and 0x42 written; no rsp_valid; req_ready=1 after release.
- With LSU_MISALIGN_TRAP_EN: half load at 0x5 -> no m_read activity; rsp_valid and rsp_misaligned=1 one cycle after accept.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between execute and a byte-addressed data memory; misaligned accesses are split into bytes.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses (no memory cycle, rsp_misaligned=1) instead of splitting them.
module dmem_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_read,
  input  logic [1:0]            req_write,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_misaligned,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [2:0]            m_read,
  output logic [1:0]            m_write,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] asm_q, asm_next;
  logic [DATA_WIDTH-1:0] rdata_q, load_result;
  logic [2:0]            read_q;
  logic [1:0]            write_q;
  logic                  is_store_q, is_load_q, misal_q;
  logic [1:0]            k_q, k_last_q;

  logic                  req_store, req_load, req_misal;
  logic [1:0]            req_size;

  // A store wins over a load when both codes are nonzero.
  assign req_store = |req_write;
  assign req_load  = !req_store && (|req_read[1:0]);
  assign req_size  = req_store ? req_write : req_read[1:0];
  assign req_misal = (req_store || req_load) &&
                     (((req_size == 2'b10) && req_addr[0]) ||
                      ((req_size == 2'b11) && (req_addr[1:0] != 2'b00)));

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] raw,
                                                   input logic [2:0]            code);
    case (code[1:0])
      2'b01:   return code[2] ? {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]}
                              : {{(DATA_WIDTH-8){1'b0}}, raw[7:0]};
      2'b10:   return code[2] ? {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]}
                              : {{(DATA_WIDTH-16){1'b0}}, raw[15:0]};
      2'b11:   return raw;
      default: return '0;
    endcase
  endfunction

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!(req_store || req_load)) state_next = RESP;
`ifdef LSU_MISALIGN_TRAP_EN
          else if (req_misal)           state_next = RESP;
`endif
          else                          state_next = ACCESS;
        end
      end
      ACCESS:  if (!misal_q || (k_q == k_last_q)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte k of a split load lands in assembly lane k; the last lane bypasses asm_q.
  always_comb begin
    asm_next                       = asm_q;
    asm_next[{k_q, 3'b000} +: 8]   = m_rdata[7:0];
    load_result                    = is_load_q ? extend(misal_q ? asm_next : m_rdata, read_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= '0;
      write_q    <= '0;
      is_store_q <= 1'b0;
      is_load_q  <= 1'b0;
      misal_q    <= 1'b0;
      k_q        <= '0;
      k_last_q   <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            read_q     <= req_read;
            write_q    <= req_write;
            is_store_q <= req_store;
            is_load_q  <= req_load;
            misal_q    <= req_misal;
            k_q        <= '0;
            k_last_q   <= (req_size == 2'b10) ? 2'd1 : 2'd3;
            asm_q      <= '0;
            if (state_next == RESP) rdata_q <= '0;
          end
        end
        ACCESS: begin
          k_q   <= k_q + 2'd1;
          asm_q <= asm_next;
          if (state_next == RESP) rdata_q <= load_result;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no latch is inferred outside ACCESS.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_read  = '0;
    m_write = '0;
    if (state == ACCESS) begin
      m_addr = addr_q + {{(ADDR_WIDTH-2){1'b0}}, k_q};
      if (misal_q) begin
        m_wdata = is_store_q ? {{(DATA_WIDTH-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]} : '0;
        m_read  = is_load_q  ? 3'b001 : 3'b000;
        m_write = is_store_q ? 2'b01  : 2'b00;
      end else begin
        m_wdata = is_store_q ? wdata_q : '0;
        m_read  = is_load_q  ? read_q  : 3'b000;
        m_write = is_store_q ? write_q : 2'b00;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_misaligned = (state == RESP) && misal_q;
`else
  assign rsp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte memory model, vector table with a response scoreboard, and hand-written corner sequences.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_dmem_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_read;
  logic [1:0]  req_write;
  logic        rsp_valid, rsp_misaligned;
  logic [31:0] rsp_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_read;
  logic [1:0]  m_write;

  dmem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misaligned(rsp_misaligned),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  code;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] exp;
    logic        mis;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  logic [7:0]  mem [logic [31:0]];
  int          mem_gen = 0;
  exp_t        exp_q[$];
  wr_t         wlog[$];
  logic [31:0] rdlog[$];
  int          rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
  int          cyc = 0, acc_cyc = 0;
  int          n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [2:0] code);
    logic [31:0] w;
    w = {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
    case (code[1:0])
      2'b01:   return code[2] ? {{24{w[7]}}, w[7:0]}   : {24'h0, w[7:0]};
      2'b10:   return code[2] ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      2'b11:   return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(m_addr or m_read or mem_gen) m_rdata = mem_word(m_addr, m_read);

  always @(posedge clk) cyc <= cyc + 1;

  // Memory side observed mid-cycle; stores commit here, before the next edge.
  always @(negedge clk) begin
    if (m_read != 3'b000) begin
      rd_cnt++;
      rdlog.push_back(m_addr);
    end
    if (m_write != 2'b00) begin
      wr_cnt++;
      wlog.push_back('{m_addr, m_wdata, m_write});
      for (int i = 0; i < ((m_write == 2'b01) ? 1 : (m_write == 2'b10) ? 2 : 4); i++)
        mem[m_addr + 32'(i)] = m_wdata[8*i +: 8];
      mem_gen++;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%08h, expected no response", rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_rdata"}, rsp_rdata, e.rdata);
        check({e.name, "_misaligned"}, 32'(rsp_misaligned), 32'(e.mis));
        check({e.name, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] exp_rdata, input logic exp_mis,
                        input int exp_lat, input int exp_nrd, input int exp_nwr,
                        input string name);
    int rd0, wr0, rsp0;
    bit got;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_read  = rd;
    req_write = wr;
    exp_q.push_back('{exp_rdata, exp_mis, exp_lat, name});
    rd0  = rd_cnt;
    wr0  = wr_cnt;
    rsp0 = rsp_cnt;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_read  = 3'b000;
    req_write = 2'b00;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) check({name, "_ready_busy"}, 32'(req_ready), 32'd0);
      if (rsp_cnt != rsp0) got = 1'b1;
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s_timeout: got no rsp_valid in 20 cycles, expected one", name);
      exp_q.delete();
    end
    check({name, "_nread"},  32'(rd_cnt - rd0), 32'(exp_nrd));
    check({name, "_nwrite"}, 32'(wr_cnt - wr0), 32'(exp_nwr));
  endtask

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int rs0;
    logic [31:0] exp_b;

    tbl[0]  = '{32'h10, 32'hDEADBEEF, 3'b000, 2'b11, 32'h0,        1'b0, 2, 0, 1};
    tbl[1]  = '{32'h10, 32'h0,        3'b011, 2'b00, 32'hDEADBEEF, 1'b0, 2, 1, 0};
    tbl[2]  = '{32'h21, 32'h00000080, 3'b000, 2'b01, 32'h0,        1'b0, 2, 0, 1};
    tbl[3]  = '{32'h21, 32'h0,        3'b101, 2'b00, 32'hFFFFFF80, 1'b0, 2, 1, 0};
    tbl[4]  = '{32'h21, 32'h0,        3'b001, 2'b00, 32'h00000080, 1'b0, 2, 1, 0};
    tbl[5]  = '{32'h12, 32'h0,        3'b010, 2'b00, 32'h0000DEAD, 1'b0, 2, 1, 0};
    tbl[6]  = '{32'h12, 32'h0,        3'b110, 2'b00, 32'hFFFFDEAD, 1'b0, 2, 1, 0};
    tbl[7]  = '{32'h44, 32'h12345678, 3'b100, 2'b00, 32'h0,        1'b0, 1, 0, 0};
    tbl[8]  = '{32'h30, 32'h123456A5, 3'b011, 2'b01, 32'h0,        1'b0, 2, 0, 1};
    tbl[9]  = '{32'h30, 32'h0,        3'b011, 2'b00, 32'h000000A5, 1'b0, 2, 1, 0};
    tbl[10] = '{32'h21, 32'h0000BEEF, 3'b000, 2'b10, 32'h0,        TRAP, TRAP ? 1 : 3, 0, TRAP ? 0 : 2};
    tbl[11] = '{32'h21, 32'h0,        3'b110, 2'b00, TRAP ? 32'h0 : 32'hFFFFBEEF, TRAP, TRAP ? 1 : 3,
                TRAP ? 0 : 2, 0};
    tbl[12] = '{32'h22, 32'h0,        3'b001, 2'b00, TRAP ? 32'h0 : 32'h000000BE, 1'b0, 2, 1, 0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_read  = '0;
    req_write = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready",      32'(req_ready),      32'd1);
    check("rst_rsp_valid",      32'(rsp_valid),      32'd0);
    check("rst_rsp_rdata",      rsp_rdata,           32'd0);
    check("rst_rsp_misaligned", 32'(rsp_misaligned), 32'd0);
    check("rst_m_addr",         m_addr,              32'd0);
    check("rst_m_wdata",        m_wdata,             32'd0);
    check("rst_m_read",         32'(m_read),         32'd0);
    check("rst_m_write",        32'(m_write),        32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      do_req(tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].wr, tbl[i].exp, tbl[i].mis,
             tbl[i].lat, tbl[i].nrd, tbl[i].nwr, $sformatf("vec%0d", i));

    // rsp_rdata must hold the last result through idle cycles.
    repeat (3) @(negedge clk);
    check("rdata_hold", rsp_rdata, tbl[12].exp);

    // Preload bytes around the top of the address space, then read a half that wraps.
    do_req(32'hFFFFFFFF, 32'h34, 3'b000, 2'b01, 32'h0, 1'b0, 2, 0, 1, "pre_top");
    do_req(32'h00000000, 32'h92, 3'b000, 2'b01, 32'h0, 1'b0, 2, 0, 1, "pre_zero");
    w0 = rdlog.size();
    do_req(32'hFFFFFFFF, 32'h0, 3'b110, 2'b00, TRAP ? 32'h0 : 32'hFFFF9234, TRAP,
           TRAP ? 1 : 3, TRAP ? 0 : 2, 0, "wrap_half");

`ifndef LSU_MISALIGN_TRAP_EN
    if (rdlog.size() >= w0 + 2) begin
      check("wrap_addr0", rdlog[w0],     32'hFFFFFFFF);
      check("wrap_addr1", rdlog[w0 + 1], 32'h00000000);
    end

    w0 = wlog.size();
    do_req(32'h13, 32'h11223344, 3'b000, 2'b11, 32'h0, 1'b0, 5, 0, 4, "mis_store");
    if (wlog.size() >= w0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_b = 32'h11223344 >> (8 * i);
        check($sformatf("mis_store_addr%0d", i), wlog[w0 + i].addr, 32'h13 + 32'(i));
        check($sformatf("mis_store_data%0d", i), wlog[w0 + i].data, {24'h0, exp_b[7:0]});
        check($sformatf("mis_store_code%0d", i), 32'(wlog[w0 + i].code), 32'd1);
      end
    end
    do_req(32'h13, 32'h0, 3'b011, 2'b00, 32'h11223344, 1'b0, 5, 4, 0, "mis_load");

    // Reset lands after two of the four byte writes of a split store.
    rs0 = rsp_cnt;
    w0  = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h41;
    req_wdata = 32'hA1B2C3D4;
    req_read  = 3'b000;
    req_write = 2'b11;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_m_write",   32'(m_write),   32'd0);
    check("abort_m_addr",    m_addr,         32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("abort_no_rsp",     32'(rsp_cnt - rs0), 32'd0);
    check("abort_ready",      32'(req_ready),     32'd1);
    check("abort_nwrite",     32'(wr_cnt - w0),   32'd2);
    check("abort_byte41",     32'(mem_rd(32'h41)), 32'hD4);
    check("abort_byte42",     32'(mem_rd(32'h42)), 32'hC3);
    check("abort_byte43",     32'(mem_rd(32'h43)), 32'h00);
    check("abort_byte44",     32'(mem_rd(32'h44)), 32'h00);
`else
    do_req(32'h13, 32'h11223344, 3'b000, 2'b11, 32'h0, 1'b1, 1, 0, 0, "trap_word_store");
    do_req(32'h5,  32'h0,        3'b010, 2'b00, 32'h0, 1'b1, 1, 0, 0, "trap_half_load");
    do_req(32'h4,  32'h0,        3'b001, 2'b00, 32'h0, 1'b0, 2, 1, 0, "trap_after_byte");
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
